wavegen: RTL
============

Name: wavegen

Overview:
- Sits directly downstream of the strobe generator (clkgen).
- Consumes its one-cycle step strobe and advances a W-bit phase counter.
- Each accepted step produces one registered unsigned audio sample: square, sawtooth, triangle or silence.
- Output feeds the DAC/PWM stage; the tone frequency is set upstream by clkgen's maxval.

Parameters:
- W, 8, sample and phase width in bits; one waveform period = 2^W accepted steps.

Ports:
- clk_i  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- step_i  in  1  one-cycle strobe from clkgen; each high cycle is one phase step
- enable_i  in  1  1 = generator runs; 0 = phase held at 0, output silent
- wave_sel_i  in  2  waveform request: 00 square, 01 saw, 10 triangle, 11 off
- duty_i  in  W  square high-time in steps (phase < duty_i -> high)
- sample_o  out  W  registered unsigned sample; midscale = 2^(W-1)
- sample_valid_o  out  1  one-cycle pulse: sample_o updated this cycle
- wrap_o  out  1  one-cycle pulse coincident with the sample for phase 2^W-1

Behaviour:
- Reset (reset=0, async) sets:
  - phase=0, sample_o=2^(W-1), sample_valid_o=0, wrap_o=0
  - mode_q=11 (off), duty_q=2^(W-1)
- Latched configuration (mode_q, duty_q):
  - Loaded from wave_sel_i/duty_i on every cycle while enable_i=0.
  - While enabled, loaded only on the edge that accepts a step with phase=2^W-1 (period wrap).
  - Mid-period changes take effect at the next period start, so there are no partial-period glitches.
- Step accept: rising edge with enable_i=1 and step_i=1:
  - sample_o <= f(phase, mode_q, duty_q), using the pre-increment phase
  - phase <= phase+1, mod 2^W (wraps 2^W-1 -> 0)
  - sample_valid_o <= 1
  - wrap_o <= (phase == 2^W-1)
- Latency: sample visible one cycle after the step_i cycle. First sample after enable is f(0).
- No step (step_i=0, enabled): phase and sample_o hold; sample_valid_o and wrap_o return to 0.
- f definitions (all W-bit unsigned):
  - square: all-ones if phase < duty_q, else 0. duty_q=0 -> constant 0. No duty value gives constant all-ones (max high time 2^W-1 of 2^W).
  - saw: phase.
  - triangle: t = {phase[W-2:0],0}; out = phase[W-1] ? ~t : t. For W=8: 0->0, 127->254, 128->255, 255->1.
  - off: 2^(W-1). sample_valid_o and wrap_o still pulse, so the downstream rate is unchanged.
- enable_i=0:
  - Next edge: phase <= 0, sample_o <= 2^(W-1), sample_valid_o <= 0, wrap_o <= 0.
  - step_i is ignored.
- enable_i rising with step_i=1 in the same cycle: the step is accepted using the configuration latched during the last disabled cycle.
- Back-to-back steps (step_i high on consecutive cycles) are legal; each is accepted.
- Reset asserted mid-period: immediate return to reset values; no pending pulse survives.

Decomposition:
- Shared package sound_pkg:
  - WAVE_SQUARE=2'b00, WAVE_SAW=2'b01, WAVE_TRI=2'b10, WAVE_OFF=2'b11
  - 2-bit wave_sel typedef/width constant
  - midscale helper constant
- Sub-module wave_shaper: purely combinational f(phase, mode, duty) -> W-bit value.
- wavegen owns phase, config latch, output registers and pulses.

Test Plan:
- Reset released, enable_i=0, W=8 -> sample_o=128, sample_valid_o=0 and wrap_o=0 for 20 cycles.
- Saw, enable=1, step every 4 cycles for 257 steps:
  - samples 0,1,...,255,0
  - sample_valid_o pulses once per step, 1 cycle after step_i
  - wrap_o only with sample 255
- Square duty_i=64, 256 steps -> 64 samples of 255 then 192 samples of 0. Repeat with duty_i=0 -> all 256 samples 0.
- Triangle, 256 back-to-back steps -> samples at phase 0,127,128,255 equal 0,254,255,1; sequence monotonic up then down.
- Mid-period switch: saw running, at phase 100 set wave_sel_i=off -> phases 100..255 remain saw; after wrap, samples = 128.
- Async reset (reset=0) asserted at phase 50, between clock edges -> outputs at reset values immediately. After release with enable=1, first sample=128 (mode off), phase restarted at 0.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants and types for the sound path (clkgen -> wavegen -> DAC/PWM).
package sound_pkg;

  localparam int WAVE_SEL_W = 2;
  typedef logic [WAVE_SEL_W-1:0] wave_sel_t;

  localparam wave_sel_t WAVE_SQUARE = 2'b00;
  localparam wave_sel_t WAVE_SAW    = 2'b01;
  localparam wave_sel_t WAVE_TRI    = 2'b10;
  localparam wave_sel_t WAVE_OFF    = 2'b11;

  // Unsigned midscale (silence level) for a w-bit sample, w <= 32.
  function automatic logic [31:0] midscale_of(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/wavegen_if.sv
// Control and sample bus between the step/config source and wavegen.
interface wavegen_if
  import sound_pkg::*;
#(
  parameter int W = 8
);
  // Handshake: no back-pressure. step_i is a one-cycle strobe and is always
  // accepted while enable_i=1; sample_valid_o is a one-cycle pulse that the
  // consumer must take in the cycle it is high (there is no ready).
  logic         step_i;
  logic         enable_i;
  wave_sel_t    wave_sel_i;
  logic [W-1:0] duty_i;
  logic [W-1:0] sample_o;
  logic         sample_valid_o;
  logic         wrap_o;

  modport master (
    output step_i, enable_i, wave_sel_i, duty_i,
    input  sample_o, sample_valid_o, wrap_o
  );

  modport slave (
    input  step_i, enable_i, wave_sel_i, duty_i,
    output sample_o, sample_valid_o, wrap_o
  );
endinterface

// File: rtl/wave_shaper.sv
// Combinational waveform function: maps phase/mode/duty to an unsigned sample.
module wave_shaper
  import sound_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] phase,
  input  wave_sel_t    mode,
  input  logic [W-1:0] duty,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MID = W'(midscale_of(W));

  logic [W-1:0] tri_ramp;

  always_comb begin
    tri_ramp = {phase[W-2:0], 1'b0};
    value    = MID;
    case (mode)
      WAVE_SQUARE: value = (phase < duty) ? '1 : '0;
      WAVE_SAW:    value = phase;
      // Second half folds the ramp back down: 128 -> 255 ... 255 -> 1 for W=8.
      WAVE_TRI:    value = phase[W-1] ? ~tri_ramp : tri_ramp;
      default:     value = MID;
    endcase
  end

endmodule

// File: rtl/wavegen.sv
// Phase-accumulating waveform generator; one registered sample per accepted step.
module wavegen
  import sound_pkg::*;
#(
  parameter int W = 8
) (
  input  logic       clk_i,
  input  logic       reset,
  wavegen_if.slave   bus
);

  localparam logic [W-1:0] MID = W'(midscale_of(W));

  logic [W-1:0] phase;
  wave_sel_t    mode_q;
  logic [W-1:0] duty_q;
  logic [W-1:0] shaped;
  logic [W-1:0] sample_q;
  logic         valid_q;
  logic         wrap_q;
  logic         at_last;

  assign at_last = (phase == '1);

  wave_shaper #(.W(W)) u_shaper (
    .phase (phase),
    .mode  (mode_q),
    .duty  (duty_q),
    .value (shaped)
  );

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      sample_q <= MID;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= WAVE_OFF;
      duty_q   <= MID;
    end else if (!bus.enable_i) begin
      phase    <= '0;
      sample_q <= MID;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= bus.wave_sel_i;
      duty_q   <= bus.duty_i;
    end else begin
      valid_q <= bus.step_i;
      wrap_q  <= bus.step_i && at_last;
      if (bus.step_i) begin
        sample_q <= shaped;
        phase    <= phase + 1'b1;
        // Config only changes at a period boundary so a period is never split.
        if (at_last) begin
          mode_q <= bus.wave_sel_i;
          duty_q <= bus.duty_i;
        end
      end
    end
  end

  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.wrap_o         = wrap_q;

endmodule
